evict_wb_ctrl: RTL and testbench



---
 rtl/evict_wb_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_evict_wb_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evict_wb_ctrl.sv
// Evict write-back controller: serializes one evicted line per handshake onto an
// address/data write channel and matches write responses against an outstanding table.

package evict_wb_pkg;
    localparam int LINE_W  = 1024;
    localparam int ADDR_W  = 48;
    localparam int TXNID_W = 8;
    localparam int ROB_W   = 6;
    localparam int DB_W    = 4;
    localparam int SB_W    = 8;

    typedef struct packed {
        logic [LINE_W-1:0]  data;
        logic [ADDR_W-1:0]  addr;
        logic [TXNID_W-1:0] txnid;
        logic [ROB_W-1:0]   rob_entry_id;
        logic [DB_W-1:0]    db_entry_id;
        logic [SB_W-1:0]    sideband;
    } evict_to_ds_pld_t;
endpackage

module evict_wb_ctrl
    import evict_wb_pkg::*;
#(
    parameter int DATA_WIDTH = LINE_W,
    parameter int BEAT_WIDTH = 256,
    parameter int BEAT_NUM   = DATA_WIDTH / BEAT_WIDTH,
    parameter int OST_NUM    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evict_to_ds_vld,
    input  evict_to_ds_pld_t      evict_to_ds_pld,
    output logic                  evict_to_ds_rdy,
    output logic                  ds_aw_vld,
    output logic [ADDR_W-1:0]     ds_aw_addr,
    output logic [TXNID_W-1:0]    ds_aw_txnid,
    input  logic                  ds_aw_rdy,
    output logic                  ds_w_vld,
    output logic [BEAT_WIDTH-1:0] ds_w_data,
    output logic                  ds_w_last,
    input  logic                  ds_w_rdy,
    input  logic                  ds_b_vld,
    input  logic [TXNID_W-1:0]    ds_b_txnid,
    output logic                  wb_done_vld,
    output logic [ROB_W-1:0]      wb_done_rob_entry_id,
    output logic                  wb_err
);
    localparam int BEAT_CW = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam int IDX_W   = (OST_NUM > 1) ? $clog2(OST_NUM) : 1;
    localparam int CNT_W   = $clog2(OST_NUM + 1);
    localparam logic [CNT_W-1:0]   OST_FULL  = CNT_W'(OST_NUM);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEAT_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

    state_t                              state_q, state_d;
    logic [BEAT_NUM-1:0][BEAT_WIDTH-1:0] line_q, line_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic [TXNID_W-1:0]                  txnid_q, txnid_d;
    logic [BEAT_CW-1:0]                  beat_q, beat_d;
    logic                                aw_vld_q, aw_vld_d;
    logic                                w_vld_q, w_vld_d;
    logic                                w_last_q, w_last_d;
    logic [OST_NUM-1:0]                  slot_vld_q, slot_vld_d;
    logic [OST_NUM-1:0][TXNID_W-1:0]     slot_txnid_q, slot_txnid_d;
    logic [OST_NUM-1:0][ROB_W-1:0]       slot_rob_q, slot_rob_d;
    logic [CNT_W-1:0]                    ost_cnt_q, ost_cnt_d;
    logic                                done_vld_q, done_vld_d;
    logic [ROB_W-1:0]                    done_rob_q, done_rob_d;
    logic                                err_q, err_d;

    logic               accept;
    logic               cam_hit;
    logic               b_hit;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   hit_idx;
    logic [BEAT_CW-1:0] beat_nxt;
    logic               unused_pld;

    assign unused_pld      = ^{evict_to_ds_pld.db_entry_id, evict_to_ds_pld.sideband};
    assign evict_to_ds_rdy = (state_q == S_IDLE) && (ost_cnt_q < OST_FULL);
    assign accept          = evict_to_ds_vld && evict_to_ds_rdy;
    assign beat_nxt        = beat_q + 1'b1;
    assign b_hit           = ds_b_vld && cam_hit;

    // Both searches look at the registered table, so a slot allocated this cycle
    // is invisible to the CAM and a slot freed this cycle cannot be reused yet.
    always_comb begin
        free_idx = '0;
        hit_idx  = '0;
        cam_hit  = 1'b0;
        for (int i = OST_NUM - 1; i >= 0; i--) begin
            if (!slot_vld_q[i]) begin
                free_idx = IDX_W'(i);
            end
            if (slot_vld_q[i] && (slot_txnid_q[i] == ds_b_txnid)) begin
                cam_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        addr_d   = addr_q;
        txnid_d  = txnid_q;
        beat_d   = beat_q;
        aw_vld_d = aw_vld_q;
        w_vld_d  = w_vld_q;
        w_last_d = w_last_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    line_d   = evict_to_ds_pld.data;
                    addr_d   = evict_to_ds_pld.addr;
                    txnid_d  = evict_to_ds_pld.txnid;
                    aw_vld_d = 1'b1;
                    state_d  = S_AW;
                end
            end
            S_AW: begin
                if (ds_aw_rdy) begin
                    aw_vld_d = 1'b0;
                    w_vld_d  = 1'b1;
                    beat_d   = '0;
                    w_last_d = (LAST_BEAT == '0);
                    state_d  = S_W;
                end
            end
            S_W: begin
                if (ds_w_rdy) begin
                    if (w_last_q) begin
                        w_vld_d  = 1'b0;
                        w_last_d = 1'b0;
                        beat_d   = '0;
                        state_d  = S_IDLE;
                    end else begin
                        beat_d   = beat_nxt;
                        w_last_d = (beat_nxt == LAST_BEAT);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_txnid_d = slot_txnid_q;
        slot_rob_d   = slot_rob_q;
        done_vld_d   = b_hit;
        done_rob_d   = done_rob_q;
        err_d        = err_q | (ds_b_vld & ~cam_hit);
        if (b_hit) begin
            slot_vld_d[hit_idx] = 1'b0;
            done_rob_d          = slot_rob_q[hit_idx];
        end
        if (accept) begin
            slot_vld_d[free_idx]   = 1'b1;
            slot_txnid_d[free_idx] = evict_to_ds_pld.txnid;
            slot_rob_d[free_idx]   = evict_to_ds_pld.rob_entry_id;
        end
        unique case ({accept, b_hit})
            2'b10:   ost_cnt_d = ost_cnt_q + 1'b1;
            2'b01:   ost_cnt_d = ost_cnt_q - 1'b1;
            default: ost_cnt_d = ost_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            addr_q       <= '0;
            txnid_q      <= '0;
            beat_q       <= '0;
            aw_vld_q     <= 1'b0;
            w_vld_q      <= 1'b0;
            w_last_q     <= 1'b0;
            slot_vld_q   <= '0;
            slot_txnid_q <= '0;
            slot_rob_q   <= '0;
            ost_cnt_q    <= '0;
            done_vld_q   <= 1'b0;
            done_rob_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            txnid_q      <= txnid_d;
            beat_q       <= beat_d;
            aw_vld_q     <= aw_vld_d;
            w_vld_q      <= w_vld_d;
            w_last_q     <= w_last_d;
            slot_vld_q   <= slot_vld_d;
            slot_txnid_q <= slot_txnid_d;
            slot_rob_q   <= slot_rob_d;
            ost_cnt_q    <= ost_cnt_d;
            done_vld_q   <= done_vld_d;
            done_rob_q   <= done_rob_d;
            err_q        <= err_d;
        end
    end

    assign ds_aw_vld            = aw_vld_q;
    assign ds_aw_addr           = addr_q;
    assign ds_aw_txnid          = txnid_q;
    assign ds_w_vld             = w_vld_q;
    assign ds_w_data            = line_q[beat_q];
    assign ds_w_last            = w_last_q;
    assign wb_done_vld          = done_vld_q;
    assign wb_done_rob_entry_id = done_rob_q;
    assign wb_err               = err_q;

endmodule

// File: tb/tb_evict_wb_ctrl.sv
// Bench for evict_wb_ctrl: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of lines in flight and outstanding writes.

module tb_evict_wb_ctrl;
    import evict_wb_pkg::*;

    localparam int BW  = 256;
    localparam int BN  = 4;
    localparam int OST = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 evict_to_ds_vld;
    evict_to_ds_pld_t     evict_to_ds_pld;
    logic                 evict_to_ds_rdy;
    logic                 ds_aw_vld;
    logic [ADDR_W-1:0]    ds_aw_addr;
    logic [TXNID_W-1:0]   ds_aw_txnid;
    logic                 ds_aw_rdy;
    logic                 ds_w_vld;
    logic [BW-1:0]        ds_w_data;
    logic                 ds_w_last;
    logic                 ds_w_rdy;
    logic                 ds_b_vld;
    logic [TXNID_W-1:0]   ds_b_txnid;
    logic                 wb_done_vld;
    logic [ROB_W-1:0]     wb_done_rob_entry_id;
    logic                 wb_err;

    always #5 clk = ~clk;

    evict_wb_ctrl #(
        .DATA_WIDTH(LINE_W),
        .BEAT_WIDTH(BW),
        .BEAT_NUM  (BN),
        .OST_NUM   (OST)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .evict_to_ds_vld     (evict_to_ds_vld),
        .evict_to_ds_pld     (evict_to_ds_pld),
        .evict_to_ds_rdy     (evict_to_ds_rdy),
        .ds_aw_vld           (ds_aw_vld),
        .ds_aw_addr          (ds_aw_addr),
        .ds_aw_txnid         (ds_aw_txnid),
        .ds_aw_rdy           (ds_aw_rdy),
        .ds_w_vld            (ds_w_vld),
        .ds_w_data           (ds_w_data),
        .ds_w_last           (ds_w_last),
        .ds_w_rdy            (ds_w_rdy),
        .ds_b_vld            (ds_b_vld),
        .ds_b_txnid          (ds_b_txnid),
        .wb_done_vld         (wb_done_vld),
        .wb_done_rob_entry_id(wb_done_rob_entry_id),
        .wb_err              (wb_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the line currently being written and the outstanding-write table.
    bit                  m_inflight;
    bit                  m_aw_sent;
    int                  m_beat;
    logic [LINE_W-1:0]   m_data;
    logic [ADDR_W-1:0]   m_addr;
    logic [TXNID_W-1:0]  m_txnid;
    bit                  s_vld [OST];
    logic [TXNID_W-1:0]  s_txn [OST];
    logic [ROB_W-1:0]    s_rob [OST];
    bit                  m_done_pend;
    logic [ROB_W-1:0]    m_done_rob;
    bit                  m_err;
    int                  dut_beats;
    int                  dut_lasts;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < OST; i++) n += int'(s_vld[i]);
        return n;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        m_inflight  = 0;
        m_aw_sent   = 0;
        m_beat      = 0;
        m_done_pend = 0;
        m_err       = 0;
        for (int i = 0; i < OST; i++) s_vld[i] = 0;
    endtask

    task automatic idle_inputs();
        evict_to_ds_vld = 1'b0;
        ds_b_vld        = 1'b0;
        ds_b_txnid      = '0;
    endtask

    task automatic set_pld(input logic [TXNID_W-1:0] t, input logic [ROB_W-1:0] r,
                           input logic [LINE_W-1:0] d, input logic [ADDR_W-1:0] a);
        evict_to_ds_pld.data         = d;
        evict_to_ds_pld.addr         = a;
        evict_to_ds_pld.txnid        = t;
        evict_to_ds_pld.rob_entry_id = r;
        evict_to_ds_pld.db_entry_id  = 4'($urandom);
        evict_to_ds_pld.sideband     = 8'($urandom);
    endtask

    // Check every output against the model, advance the model by this cycle's handshakes, then clock.
    task automatic cycle();
        bit exp_rdy;
        bit acc;
        bit hit;
        int hi;
        int fi;
        exp_rdy = !m_inflight && (occupancy() < OST);
        chk("evict_rdy", evict_to_ds_rdy, exp_rdy);
        chk("aw_vld", ds_aw_vld, m_inflight && !m_aw_sent);
        chk("w_vld", ds_w_vld, m_inflight && m_aw_sent);
        if (m_inflight && !m_aw_sent) begin
            chk("aw_addr", ds_aw_addr, m_addr);
            chk("aw_txnid", ds_aw_txnid, m_txnid);
        end
        if (m_inflight && m_aw_sent) begin
            chk("w_data", ds_w_data, m_data[m_beat*BW +: BW]);
            chk("w_last", ds_w_last, m_beat == BN - 1);
        end
        chk("done_vld", wb_done_vld, m_done_pend);
        if (m_done_pend) chk("done_rob", wb_done_rob_entry_id, m_done_rob);
        chk("wb_err", wb_err, m_err);
        if (ds_w_vld && ds_w_rdy) begin
            dut_beats++;
            if (ds_w_last) dut_lasts++;
        end

        hit = 0;
        hi  = 0;
        for (int i = 0; i < OST; i++)
            if (!hit && ds_b_vld && s_vld[i] && s_txn[i] == ds_b_txnid) begin
                hit = 1;
                hi  = i;
            end
        fi = 0;
        for (int i = OST - 1; i >= 0; i--) if (!s_vld[i]) fi = i;
        acc = evict_to_ds_vld && exp_rdy;

        m_done_pend = hit;
        if (hit) begin
            m_done_rob = s_rob[hi];
            s_vld[hi]  = 0;
        end
        if (ds_b_vld && !hit) m_err = 1;
        if (m_inflight && m_aw_sent && ds_w_rdy) begin
            if (m_beat == BN - 1) m_inflight = 0;
            else m_beat++;
        end else if (m_inflight && !m_aw_sent && ds_aw_rdy) begin
            m_aw_sent = 1;
            m_beat    = 0;
        end
        if (acc) begin
            s_vld[fi]  = 1;
            s_txn[fi]  = evict_to_ds_pld.txnid;
            s_rob[fi]  = evict_to_ds_pld.rob_entry_id;
            m_inflight = 1;
            m_aw_sent  = 0;
            m_beat     = 0;
            m_data     = evict_to_ds_pld.data;
            m_addr     = evict_to_ds_pld.addr;
            m_txnid    = evict_to_ds_pld.txnid;
        end
        @(posedge clk);
        #1;
    endtask

    // Raises reset between clock edges and checks that outputs clear without a clock.
    task automatic apply_reset();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rdy", evict_to_ds_rdy, 1);
        chk("rst_aw_vld", ds_aw_vld, 0);
        chk("rst_w_vld", ds_w_vld, 0);
        chk("rst_w_last", ds_w_last, 0);
        chk("rst_done_vld", wb_done_vld, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_aw_addr", ds_aw_addr, 0);
        chk("rst_aw_txnid", ds_aw_txnid, 0);
        chk("rst_w_data", ds_w_data, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_line(input logic [TXNID_W-1:0] t, input logic [ROB_W-1:0] r,
                             input logic [LINE_W-1:0] d, input logic [ADDR_W-1:0] a);
        int g   = 0;
        bit acc = 0;
        set_pld(t, r, d, a);
        evict_to_ds_vld = 1'b1;
        while (!acc && g < 50) begin
            acc = evict_to_ds_rdy;
            cycle();
            g++;
        end
        evict_to_ds_vld = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (m_inflight && g < 50) begin
            cycle();
            g++;
        end
        chk(tag, ds_aw_vld | ds_w_vld, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] d;
        logic [LINE_W-1:0] d2;
        logic [31:0]       w;
        int                n;
        int                g;
        bit                acc;
        int                q[$];

        rst       = 1'b0;
        ds_aw_rdy = 1'b0;
        ds_w_rdy  = 1'b0;
        idle_inputs();
        set_pld('0, '0, '0, '0);
        apply_reset();

        // Single line, all ready.
        ds_aw_rdy = 1'b1;
        ds_w_rdy  = 1'b1;
        for (int b = 0; b < BN; b++) begin
            w = 32'hA5A5_0000 + 32'(b);
            d[b*BW +: BW] = {8{w}};
        end
        send_line(8'd3, 6'd5, d, 48'h1000);
        chk("t1_aw_n1", ds_aw_vld, 1);
        chk("t1_aw_addr", ds_aw_addr, 48'h1000);
        cycle();
        for (int b = 0; b < BN; b++) begin
            w = 32'hA5A5_0000 + 32'(b);
            chk("t1_beat_data", ds_w_data, {8{w}});
            chk("t1_beat_last", ds_w_last, b == BN - 1);
            cycle();
        end
        chk("t1_idle_rdy", evict_to_ds_rdy, 1);
        chk("t1_idle_wvld", ds_w_vld, 0);
        repeat (4) cycle();
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'd3;
        cycle();
        ds_b_vld = 1'b0;
        chk("t1_done_vld", wb_done_vld, 1);
        chk("t1_done_rob", wb_done_rob_entry_id, 6'd5);
        cycle();
        chk("t1_done_one_cycle", wb_done_vld, 0);

        // Backpressure on address then data.
        apply_reset();
        ds_aw_rdy = 1'b0;
        ds_w_rdy  = 1'b0;
        d = rand_line();
        send_line(8'd4, 6'd6, d, 48'h2000);
        repeat (3) begin
            chk("t2_aw_hold", ds_aw_vld, 1);
            chk("t2_aw_addr_hold", ds_aw_addr, 48'h2000);
            cycle();
        end
        ds_aw_rdy = 1'b1;
        cycle();
        ds_aw_rdy = 1'b0;
        dut_beats = 0;
        dut_lasts = 0;
        g = 0;
        while (m_inflight && g < 40) begin
            ds_w_rdy = g[0];
            cycle();
            g++;
        end
        ds_w_rdy = 1'b0;
        chk("t2_beats", dut_beats, 4);
        chk("t2_lasts", dut_lasts, 1);
        chk("t2_finished", ds_w_vld, 0);

        // Fill the table, hold off a ninth line, free one slot.
        apply_reset();
        ds_aw_rdy = 1'b1;
        ds_w_rdy  = 1'b1;
        evict_to_ds_vld = 1'b1;
        n = 0;
        g = 0;
        while (n < 8 && g < 100) begin
            set_pld(8'(16 + n), 6'(n), rand_line(), 48'(32'h3000 + n * 64));
            acc = evict_to_ds_rdy;
            cycle();
            if (acc) n++;
            g++;
        end
        chk("t3_accepts", n, 8);
        set_pld(8'h30, 6'd40, rand_line(), 48'h3800);
        repeat (8) cycle();
        chk("t3_full_rdy", evict_to_ds_rdy, 0);
        chk("t3_ninth_held", ds_aw_vld, 0);
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'd18;
        cycle();
        ds_b_vld = 1'b0;
        chk("t3_rdy_back", evict_to_ds_rdy, 1);
        chk("t3_done_rob", wb_done_rob_entry_id, 6'd2);
        cycle();
        evict_to_ds_vld = 1'b0;
        chk("t3_ninth_aw", ds_aw_vld, 1);
        wait_idle("t3_drain");

        // Out-of-order responses.
        apply_reset();
        send_line(8'd1, 6'd10, rand_line(), 48'h4000);
        send_line(8'd2, 6'd11, rand_line(), 48'h4040);
        send_line(8'd3, 6'd12, rand_line(), 48'h4080);
        wait_idle("t4_drain");
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'd3;
        cycle();
        chk("t4_done_a", wb_done_vld, 1);
        chk("t4_rob_a", wb_done_rob_entry_id, 6'd12);
        ds_b_txnid = 8'd1;
        cycle();
        chk("t4_done_b", wb_done_vld, 1);
        chk("t4_rob_b", wb_done_rob_entry_id, 6'd10);
        ds_b_txnid = 8'd2;
        cycle();
        ds_b_vld = 1'b0;
        chk("t4_done_c", wb_done_vld, 1);
        chk("t4_rob_c", wb_done_rob_entry_id, 6'd11);
        cycle();

        // Unmatched response.
        send_line(8'd9, 6'd20, rand_line(), 48'h4100);
        wait_idle("t5_drain");
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'h7F;
        cycle();
        ds_b_vld = 1'b0;
        chk("t5_err_set", wb_err, 1);
        chk("t5_no_done", wb_done_vld, 0);
        repeat (3) cycle();
        chk("t5_err_sticky", wb_err, 1);
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'd9;
        cycle();
        ds_b_vld = 1'b0;
        chk("t5_entry_kept", wb_done_vld, 1);
        chk("t5_entry_rob", wb_done_rob_entry_id, 6'd20);
        cycle();

        // Reset in the middle of beat 2.
        apply_reset();
        d = rand_line();
        send_line(8'h0A, 6'd21, d, 48'h5000);
        cycle();
        cycle();
        cycle();
        chk("t6_at_beat2", ds_w_data, d[2*BW +: BW]);
        apply_reset();
        d2 = rand_line();
        send_line(8'h0B, 6'd22, d2, 48'h5100);
        chk("t6_new_aw", ds_aw_txnid, 8'h0B);
        cycle();
        chk("t6_first_beat", ds_w_data, d2[BW-1:0]);
        wait_idle("t6_drain");
        ds_b_vld   = 1'b1;
        ds_b_txnid = 8'h0A;
        cycle();
        chk("t6_old_dropped", wb_done_vld, 0);
        ds_b_txnid = 8'h0B;
        cycle();
        ds_b_vld = 1'b0;
        chk("t6_new_done", wb_done_vld, 1);
        chk("t6_new_rob", wb_done_rob_entry_id, 6'd22);
        cycle();

        // Randomized traffic.
        apply_reset();
        repeat (400) begin
            ds_aw_rdy       = ($urandom % 4) != 0;
            ds_w_rdy        = ($urandom % 4) != 0;
            evict_to_ds_vld = ($urandom % 3) == 0;
            set_pld(8'($urandom % 16), 6'($urandom), rand_line(), 48'({$urandom, $urandom}));
            q.delete();
            for (int i = 0; i < OST; i++) if (s_vld[i]) q.push_back(i);
            ds_b_vld = 1'b0;
            if (q.size() > 0 && ($urandom % 3) == 0) begin
                ds_b_vld   = 1'b1;
                ds_b_txnid = s_txn[q[$urandom % q.size()]];
            end else if (($urandom % 40) == 0) begin
                ds_b_vld   = 1'b1;
                ds_b_txnid = 8'h7F;
            end
            cycle();
        end
        idle_inputs();
        ds_aw_rdy = 1'b1;
        ds_w_rdy  = 1'b1;
        wait_idle("t7_drain");
        for (int i = 0; i < OST; i++) begin
            if (s_vld[i]) begin
                ds_b_vld   = 1'b1;
                ds_b_txnid = s_txn[i];
                cycle();
            end
        end
        ds_b_vld = 1'b0;
        cycle();
        chk("t7_empty_rdy", evict_to_ds_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
